vec_mem_sequencer: RTL and testbench

- Multi-cycle vector load/store engine sitting directly downstream of Control_Unit in the vector ASIP datapath.
- Control_Unit raises a memory operation (start, we). This block moves LANES elements one at a time over a scalar req/ack memory port.
- It returns Mem_Finished, which Control_Unit consumes to release the pipeline stall.

---
 rtl/vasip_pkg.sv | 15 +
 rtl/vec_mem_sequencer_if.sv | 34 +++
 rtl/vec_mem_sequencer.sv | 129 ++++++++++++
 tb/tb_vec_mem_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/vasip_pkg.sv
// Shared vector-ASIP constants and the memory-sequencer state type.
// Used by the register file, Control_Unit and vec_mem_sequencer.
package vasip_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned ELEM_W = 8;
  localparam int unsigned ADDR_W = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StXfer = 2'd1,
    StDone = 2'd2
  } vmem_state_t;

endpackage

// File: rtl/vec_mem_sequencer_if.sv
// Scalar element port between vec_mem_sequencer (master) and data memory (slave).
interface vec_mem_sequencer_if
  import vasip_pkg::*;
#(
  parameter int unsigned AddrW = ADDR_W,
  parameter int unsigned ElemW = ELEM_W
);

  logic             mem_req;
  logic             mem_we;
  logic [AddrW-1:0] mem_addr;
  logic [ElemW-1:0] mem_wdata;
  logic             mem_ack;
  logic [ElemW-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/vec_mem_sequencer.sv
// Vector load/store sequencer: moves Lanes elements over a scalar req/ack port.
// Optional VMEM_STRIDE_EN adds a stride_i input (default build is unit-stride).
module vec_mem_sequencer
  import vasip_pkg::*;
#(
  parameter int unsigned Lanes = LANES,
  parameter int unsigned ElemW = ELEM_W,
  parameter int unsigned AddrW = ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   we_i,
  input  logic [AddrW-1:0]       base_addr_i,
`ifdef VMEM_STRIDE_EN
  input  logic [AddrW-1:0]       stride_i,
`endif
  input  logic [Lanes*ElemW-1:0] st_data_i,
  output logic [Lanes*ElemW-1:0] ld_data_o,
  output logic                   mem_finished_o,
  output logic                   busy_o,
  vec_mem_sequencer_if.master    mem_if
);

  localparam int unsigned IdxW = $clog2(Lanes);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Lanes - 1);

  vmem_state_t            state_q, state_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic                   we_q, we_d;
  logic [AddrW-1:0]       addr_q, addr_d;
  logic [Lanes*ElemW-1:0] st_data_q, st_data_d;
  logic [Lanes*ElemW-1:0] ld_data_q, ld_data_d;
  logic [AddrW-1:0]       step;

`ifdef VMEM_STRIDE_EN
  logic [AddrW-1:0] stride_q, stride_d;

  assign stride_d = (state_q == StIdle && start_i) ? stride_i : stride_q;
  assign step     = stride_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stride_q <= '0;
    end else begin
      stride_q <= stride_d;
    end
  end
`else
  assign step = AddrW'(1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      st_data_q <= '0;
      ld_data_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      st_data_q <= st_data_d;
      ld_data_q <= ld_data_d;
    end
  end

  // addr_q accumulates the element address so no multiplier is needed for strides.
  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    we_d             = we_q;
    addr_d           = addr_q;
    st_data_d        = st_data_q;
    ld_data_d        = ld_data_q;
    mem_if.mem_req   = 1'b0;
    mem_if.mem_we    = 1'b0;
    mem_if.mem_addr  = '0;
    mem_if.mem_wdata = '0;
    mem_finished_o   = 1'b0;
    busy_o           = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d   = StXfer;
          we_d      = we_i;
          addr_d    = base_addr_i;
          st_data_d = st_data_i;
          idx_d     = '0;
          ld_data_d = '0;
        end
      end
      StXfer: begin
        busy_o           = 1'b1;
        mem_if.mem_req   = 1'b1;
        mem_if.mem_we    = we_q;
        mem_if.mem_addr  = addr_q;
        mem_if.mem_wdata = st_data_q[idx_q*ElemW +: ElemW];
        if (mem_if.mem_ack) begin
          if (!we_q) begin
            ld_data_d[idx_q*ElemW +: ElemW] = mem_if.mem_rdata;
          end
          addr_d = addr_q + step;
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StDone: begin
        mem_finished_o = 1'b1;
        if (!start_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign ld_data_o = ld_data_q;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed bench for vec_mem_sequencer with a req/ack memory model (rdata = addr[7:0]).
module tb_vec_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        we = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] stride = 16'd1;
  logic [31:0] st_data = '0;
  logic [31:0] ld_data;
  logic        fin;
  logic        busy;
  logic        force_ack = 1'b0;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  int          n_checks = 0;
  int          n_errs = 0;

  vec_mem_sequencer_if m_if ();

  vec_mem_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start),
    .we_i           (we),
    .base_addr_i    (base_addr),
`ifdef VMEM_STRIDE_EN
    .stride_i       (stride),
`endif
    .st_data_i      (st_data),
    .ld_data_o      (ld_data),
    .mem_finished_o (fin),
    .busy_o         (busy),
    .mem_if         (m_if.master)
  );

  always #5 clk = ~clk;

  // Memory: ack after ack_delay cycles of req, rdata mirrors the low address byte.
  assign m_if.mem_ack   = force_ack | (m_if.mem_req & (wait_cnt >= ack_delay));
  assign m_if.mem_rdata = m_if.mem_addr[7:0];

  always @(posedge clk) begin
    if (m_if.mem_req && !m_if.mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_op(input string tag, input logic [15:0] base,
                         input logic [15:0] a0, input logic [15:0] a1,
                         input logic [15:0] a2, input logic [15:0] a3,
                         input logic [31:0] exp_ld);
    logic [15:0] exp_a [4];
    exp_a = '{a0, a1, a2, a3};
    start = 1'b1; we = 1'b0; base_addr = base; ack_delay = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq({tag, "_addr"}, 64'(m_if.mem_addr), 64'(exp_a[i]));
      check_eq({tag, "_req"}, 64'(m_if.mem_req), 64'd1);
    end
    tick();
    check_eq({tag, "_fin"}, 64'(fin), 64'd1);
    check_eq({tag, "_ld"}, 64'(ld_data), 64'(exp_ld));
    start = 1'b0;
    tick();
    check_eq({tag, "_idle"}, 64'(fin), 64'd0);
  endtask

  initial begin
    logic [7:0] wd [4];
    wd = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    // Reset state
    #12;
    check_eq("rst_req", 64'(m_if.mem_req), 64'd0);
    check_eq("rst_fin", 64'(fin), 64'd0);
    check_eq("rst_ld", 64'(ld_data), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("idle_busy", 64'(busy), 64'd0);

    // Load, ack tied high; start held after completion
    start = 1'b1; we = 1'b0; base_addr = 16'h0010; ack_delay = 0;
    for (int n = 0; n < 4; n++) begin
      tick();
      check_eq("t1_addr", 64'(m_if.mem_addr), 64'h10 + 64'(n));
      check_eq("t1_busy", 64'(busy), 64'd1);
      check_eq("t1_fin_early", 64'(fin), 64'd0);
    end
    tick();
    check_eq("t1_fin", 64'(fin), 64'd1);
    check_eq("t1_req_done", 64'(m_if.mem_req), 64'd0);
    check_eq("t1_ld", 64'(ld_data), 64'h13121110);
    for (int n = 0; n < 2; n++) begin
      tick();
      check_eq("t5_fin_hold", 64'(fin), 64'd1);
      check_eq("t5_no_req", 64'(m_if.mem_req), 64'd0);
    end
    start = 1'b0;
    tick();
    check_eq("t5_fin_low", 64'(fin), 64'd0);
    check_eq("t5_ld_hold", 64'(ld_data), 64'h13121110);
    force_ack = 1'b1;
    tick();
    check_eq("ack_idle_req", 64'(m_if.mem_req), 64'd0);
    check_eq("ack_idle_busy", 64'(busy), 64'd0);
    force_ack = 1'b0;

    // Store, ack after 2 wait cycles per element
    start = 1'b1; we = 1'b1; base_addr = 16'h0020; st_data = 32'hDDCCBBAA; ack_delay = 2;
    for (int e = 0; e < 4; e++) begin
      for (int c = 0; c < 3; c++) begin
        tick();
        check_eq("t2_addr", 64'(m_if.mem_addr), 64'h20 + 64'(e));
        check_eq("t2_wdata", 64'(m_if.mem_wdata), 64'(wd[e]));
        check_eq("t2_we", 64'(m_if.mem_we), 64'd1);
        check_eq("t2_fin_early", 64'(fin), 64'd0);
      end
    end
    tick();
    check_eq("t2_fin", 64'(fin), 64'd1);
    check_eq("t2_ld_cleared", 64'(ld_data), 64'd0);
    start = 1'b0;
    tick();
    check_eq("t2_idle", 64'(fin), 64'd0);

    // Address wrap
    load_op("t3", 16'hFFFE, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 32'h0100FFFE);

    // start dropped after element 1 is acked
    start = 1'b1; we = 1'b0; base_addr = 16'h0040; ack_delay = 0;
    tick();
    check_eq("t4_addr0", 64'(m_if.mem_addr), 64'h40);
    tick();
    check_eq("t4_addr1", 64'(m_if.mem_addr), 64'h41);
    tick();
    start = 1'b0;
    check_eq("t4_addr2", 64'(m_if.mem_addr), 64'h42);
    tick();
    check_eq("t4_addr3", 64'(m_if.mem_addr), 64'h43);
    tick();
    check_eq("t4_fin", 64'(fin), 64'd1);
    tick();
    check_eq("t4_fin_pulse", 64'(fin), 64'd0);
    check_eq("t4_busy", 64'(busy), 64'd0);
    check_eq("t4_ld", 64'(ld_data), 64'h43424140);

    // Reset mid-transfer at idx=2
    start = 1'b1; base_addr = 16'h0050;
    tick();
    tick();
    tick();
    check_eq("t6_addr2", 64'(m_if.mem_addr), 64'h52);
    start = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_eq("t6_req", 64'(m_if.mem_req), 64'd0);
    check_eq("t6_addr", 64'(m_if.mem_addr), 64'd0);
    check_eq("t6_busy", 64'(busy), 64'd0);
    check_eq("t6_ld", 64'(ld_data), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("t6_post_fin", 64'(fin), 64'd0);
    check_eq("t6_post_busy", 64'(busy), 64'd0);
    load_op("t6_again", 16'h0060, 16'h0060, 16'h0061, 16'h0062, 16'h0063, 32'h63626160);

`ifdef VMEM_STRIDE_EN
    stride = 16'd4;
    load_op("t7_stride", 16'h0100, 16'h0100, 16'h0104, 16'h0108, 16'h010C, 32'h0C080400);
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
